mips_run_controller: RTL

Sequencer that owns the MIPS core's load/run/debug lifecycle. It drains a program from the instruction FIFO into program memory, then runs the core either freely or one cycle per step command, using a synchronous clock enable rather than a gated clock. It hands off to the debug unit for a register/memory dump after each step or at program completion. It sits between the UART/FIFO front end, the MIPS core and the debug unit.

---
 rtl/mips_ctrl_pkg.sv | 35 +++
 rtl/pm_loader.sv | 52 +++++
 rtl/mips_run_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared state encoding, command codes and header clamp for the MIPS run controller.
package mips_ctrl_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR       = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_STEP_WAIT = 3'd4;
  localparam logic [2:0] S_STEP_EXEC = 3'd5;
  localparam logic [2:0] S_DUMP      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_HDR       = S_HDR,
    ST_LOAD      = S_LOAD,
    ST_RUN       = S_RUN,
    ST_STEP_WAIT = S_STEP_WAIT,
    ST_STEP_EXEC = S_STEP_EXEC,
    ST_DUMP      = S_DUMP,
    ST_DONE      = S_DONE
  } state_t;

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  // A zero or oversized word count means "fill the whole program memory".
  function automatic int unsigned clamp_count(input logic [31:0] hdr, input int unsigned depth);
    if (hdr == 32'd0 || hdr > depth) return depth;
    return hdr;
  endfunction

endpackage

// File: rtl/pm_loader.sv
// Drains header + program words from a FWFT FIFO into program memory.
// Pop-to-write latency 1 cycle; an empty FIFO stalls the load with no write.
module pm_loader
  import mips_ctrl_pkg::*;
#(
  parameter int PM_DEPTH = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_hdr,
  input  logic              in_load,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              hdr_done,
  output logic              load_done,
  output logic              pm_wr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_data
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] last_idx;

  assign fifo_rd   = (in_hdr || in_load) && !fifo_empty;
  assign hdr_done  = in_hdr && !fifo_empty;
  assign load_done = in_load && !fifo_empty && (wr_ptr == last_idx);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      last_idx <= '0;
      pm_wr    <= 1'b0;
      pm_addr  <= '0;
      pm_data  <= '0;
    end else begin
      pm_wr <= 1'b0;
      if (hdr_done) begin
        wr_ptr   <= '0;
        last_idx <= ADDR_W'(clamp_count(32'(fifo_data), PM_DEPTH) - 1);
      end else if (in_load && !fifo_empty) begin
        pm_wr   <= 1'b1;
        pm_addr <= wr_ptr;
        pm_data <= fifo_data;
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_run_controller.sv
// Load/run/step/dump sequencer for the MIPS core; core runs under a registered clock enable.
// Commands accepted only when O_CMD_READY; RUN_CYCLE_LIMIT_EN adds a MAX_CYCLES run watchdog.
module mips_run_controller
  import mips_ctrl_pkg::*;
#(
  parameter int PM_DEPTH   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int MAX_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_FIFO_EMPTY,
  input  logic [DATA_W-1:0] I_FIFO_DATA,
  output logic              O_FIFO_RD,
  input  logic              I_CMD_VALID,
  input  logic [1:0]        I_CMD,
  output logic              O_CMD_READY,
  output logic              O_PM_WR,
  output logic [ADDR_W-1:0] O_PM_ADDR,
  output logic [DATA_W-1:0] O_PM_DATA,
  output logic              O_MIPS_EN,
  input  logic              I_MIPS_FINISHED,
  output logic              O_DUMP_REQ,
  input  logic              I_DUMP_DONE,
  output logic [2:0]        O_STATE,
  output logic [31:0]       O_CYCLES,
  output logic              O_TIMEOUT
);

`ifdef RUN_CYCLE_LIMIT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [31:0] WD_LAST = 32'(MAX_CYCLES - 1);

  state_t state;
  logic   loaded;
  logic   step_mode;
  logic   fin_seen;
  logic   out_of_reset;
  logic   hdr_done;
  logic   load_done;
  logic   cmd_acc;
  logic   wd_hit;

  // READY stays low for the first cycle after reset so every output is 0 while in reset.
  assign O_CMD_READY = out_of_reset && (state == ST_IDLE || state == ST_STEP_WAIT);
  assign cmd_acc     = I_CMD_VALID && O_CMD_READY;
  assign O_STATE     = state;
  assign wd_hit      = WD_EN && (state == ST_RUN) && (O_CYCLES >= WD_LAST);

  pm_loader #(
    .PM_DEPTH (PM_DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_pm_loader (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_hdr     (state == ST_HDR),
    .in_load    (state == ST_LOAD),
    .fifo_empty (I_FIFO_EMPTY),
    .fifo_data  (I_FIFO_DATA),
    .fifo_rd    (O_FIFO_RD),
    .hdr_done   (hdr_done),
    .load_done  (load_done),
    .pm_wr      (O_PM_WR),
    .pm_addr    (O_PM_ADDR),
    .pm_data    (O_PM_DATA)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      loaded       <= 1'b0;
      step_mode    <= 1'b0;
      fin_seen     <= 1'b0;
      out_of_reset <= 1'b0;
      O_MIPS_EN    <= 1'b0;
      O_DUMP_REQ   <= 1'b0;
      O_CYCLES     <= '0;
      O_TIMEOUT    <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      O_DUMP_REQ   <= 1'b0;
      if (O_MIPS_EN && O_CYCLES != '1)
        O_CYCLES <= O_CYCLES + 32'd1;

      unique case (state)
        ST_IDLE: begin
          if (cmd_acc) begin
            case (I_CMD)
              CMD_LOAD: begin
                state  <= ST_HDR;
                loaded <= 1'b0;
              end
              CMD_RUN: if (loaded) begin
                state     <= ST_RUN;
                step_mode <= 1'b0;
                fin_seen  <= 1'b0;
                O_MIPS_EN <= 1'b1;
              end
              CMD_STEP: if (loaded) begin
                state     <= ST_STEP_EXEC;
                step_mode <= 1'b1;
                fin_seen  <= 1'b0;
                O_MIPS_EN <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        ST_HDR: begin
          O_CYCLES  <= '0;
          O_TIMEOUT <= 1'b0;
          if (hdr_done) state <= ST_LOAD;
        end

        ST_LOAD: begin
          if (load_done) begin
            state  <= ST_IDLE;
            loaded <= 1'b1;
          end
        end

        ST_RUN: begin
          if (I_MIPS_FINISHED || wd_hit) begin
            O_MIPS_EN  <= 1'b0;
            O_DUMP_REQ <= 1'b1;
            fin_seen   <= I_MIPS_FINISHED;
            state      <= ST_DUMP;
            if (wd_hit) O_TIMEOUT <= 1'b1;
          end
        end

        ST_STEP_EXEC: begin
          O_MIPS_EN  <= 1'b0;
          O_DUMP_REQ <= 1'b1;
          state      <= ST_DUMP;
          if (I_MIPS_FINISHED) fin_seen <= 1'b1;
        end

        ST_DUMP: begin
          if (I_MIPS_FINISHED) fin_seen <= 1'b1;
          if (I_DUMP_DONE)
            state <= (step_mode && !fin_seen && !I_MIPS_FINISHED) ? ST_STEP_WAIT : ST_DONE;
        end

        ST_STEP_WAIT: begin
          if (cmd_acc) begin
            if (I_CMD == CMD_STEP) begin
              state     <= ST_STEP_EXEC;
              O_MIPS_EN <= 1'b1;
            end else if (I_CMD == CMD_ABORT) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          loaded <= 1'b0;
        end
      endcase
    end
  end

endmodule
